// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch unit: reset vector, FSM encoding and the
// active-low Jump convention. Imported by pc_fetch and npc_calc.
package pc_fetch_pkg;

    localparam logic [31:0] RESET_PC      = 32'h0000_3000;
    localparam logic        JUMP_ASSERTED = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

    // Word offset of a branch: sign-extended immediate scaled to bytes.
    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC arithmetic: PC+4 and the redirect target selected by
// Jump-over-Branch priority. All sums wrap modulo 2^32.
module npc_calc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        branch_i,
    input  logic        jumpN_i,
    input  logic        zero_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] target26_i,
    output logic [31:0] pcPlus4_o,
    output logic [31:0] target_o,
    output logic        redirect_o
);

    always_comb begin
        pcPlus4_o  = pc_i + 32'd4;
        target_o   = pcPlus4_o;
        redirect_o = 1'b0;
        if (jumpN_i == JUMP_ASSERTED) begin
            target_o   = {pcPlus4_o[31:28], target26_i, 2'b00};
            redirect_o = 1'b1;
        end else if (branch_i && zero_i) begin
            target_o   = pcPlus4_o + branchOffset(imm16_i);
            redirect_o = 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: IDLE -> FETCH -> ISSUE -> FETCH with an imem
// request/ack handshake. Define PC_FETCH_DELAY_SLOT_EN for branch delay slots.
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [15:0] Imm16,
    input  logic [25:0] Target26,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] LinkAddr,
    output logic [31:0] RetireCnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retireCnt_q, retireCnt_d;
    logic [31:0]  pcPlus4;
    logic [31:0]  redirectTarget;
    logic         redirect;
    logic         issueFire;

    npc_calc uNpcCalc (
        .pc_i       (pc_q),
        .branch_i   (Branch),
        .jumpN_i    (Jump),
        .zero_i     (Zero),
        .imm16_i    (Imm16),
        .target26_i (Target26),
        .pcPlus4_o  (pcPlus4),
        .target_o   (redirectTarget),
        .redirect_o (redirect)
    );

    assign issueFire = (state_q == ST_ISSUE) && !Stall;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_ISSUE;
            ST_ISSUE: if (!Stall)   state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        InstrValid = 1'b0;
        unique case (state_q)
            ST_FETCH: imem_req   = 1'b1;
            ST_ISSUE: InstrValid = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        instr_d     = instr_q;
        retireCnt_d = retireCnt_q;
        if (state_q == ST_FETCH && imem_ack) instr_d = imem_rdata;
        if (issueFire) retireCnt_d = retireCnt_q + 32'd1;
    end

`ifdef PC_FETCH_DELAY_SLOT_EN
    logic        pendValid_q, pendValid_d;
    logic [31:0] pendTarget_q, pendTarget_d;

    // A taken redirect parks its target while the delay slot is fetched;
    // whatever the delay-slot instruction requests is dropped.
    always_comb begin
        pc_d         = pc_q;
        pendValid_d  = pendValid_q;
        pendTarget_d = pendTarget_q;
        if (issueFire) begin
            if (pendValid_q) begin
                pc_d        = pendTarget_q;
                pendValid_d = 1'b0;
            end else if (redirect) begin
                pc_d         = pcPlus4;
                pendValid_d  = 1'b1;
                pendTarget_d = redirectTarget;
            end else begin
                pc_d = pcPlus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pendValid_q  <= 1'b0;
            pendTarget_q <= '0;
        end else begin
            pendValid_q  <= pendValid_d;
            pendTarget_q <= pendTarget_d;
        end
    end

    assign LinkAddr = pcPlus4 + 32'd4;
`else
    always_comb begin
        pc_d = pc_q;
        if (issueFire) pc_d = redirect ? redirectTarget : pcPlus4;
    end

    assign LinkAddr = pcPlus4;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            retireCnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            retireCnt_q <= retireCnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign Instr     = instr_q;
    assign RetireCnt = retireCnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; expectations follow the
// PC_FETCH_DELAY_SLOT_EN setting of the build.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic        Branch, Jump, Zero, Stall;
    logic [15:0] Imm16;
    logic [25:0] Target26;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] LinkAddr;
    logic [31:0] RetireCnt;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] expRetire   = '0;

    pc_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .Branch     (Branch),
        .Jump       (Jump),
        .Zero       (Zero),
        .Imm16      (Imm16),
        .Target26   (Target26),
        .Stall      (Stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .LinkAddr   (LinkAddr),
        .RetireCnt  (RetireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait (bounded) for a fetch request, then acknowledge it once.
    task automatic fetchInstr(input logic [31:0] rdata);
        int waited = 0;
        while (imem_req !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        nCompared++;
        if (imem_req !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fetch_wait: imem_req=%b required 1", imem_req);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic issueInstr(input logic b, input logic j, input logic z,
                              input logic [15:0] imm, input logic [25:0] tgt);
        Branch = b; Jump = j; Zero = z; Imm16 = imm; Target26 = tgt; Stall = 1'b0;
        @(negedge clk);
        Branch = 1'b0; Jump = 1'b1; Zero = 1'b0; Imm16 = '0; Target26 = '0;
        expRetire = expRetire + 32'd1;
    endtask

    // Taken redirect; in a delay-slot build also retire a plain delay slot.
    task automatic redirectInstr(input logic b, input logic j, input logic z,
                                 input logic [15:0] imm, input logic [25:0] tgt);
        issueInstr(b, j, z, imm, tgt);
`ifdef PC_FETCH_DELAY_SLOT_EN
        fetchInstr(32'h0000_0000);
        issueInstr(1'b0, 1'b1, 1'b0, 16'h0000, 26'h0);
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1; Branch = 1'b0; Jump = 1'b1; Zero = 1'b0; Stall = 1'b0;
        Imm16 = '0; Target26 = '0; imem_ack = 1'b0; imem_rdata = '0;
        repeat (3) @(negedge clk);
        nCompared++;
        if (imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req: got %b required 0", imem_req); end
        nCompared++;
        if (InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b required 0", InstrValid); end
        nCompared++;
        if (PC !== 32'h0000_3000) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h required 00003000", PC); end
        nCompared++;
        if (RetireCnt !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_retire: got %h required 0", RetireCnt); end
        nCompared++;
        if (Instr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_instr: got %h required 0", Instr); end
        expRetire = '0;

        // Ack during the IDLE cycle must be ignored.
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        nCompared++;
        if (imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL first_fetch_req: got %b required 1", imem_req); end
        nCompared++;
        if (imem_addr !== 32'h0000_3000) begin nMismatched++; $display("[TB] FAIL first_fetch_addr: got %h required 00003000", imem_addr); end
        nCompared++;
        if (InstrValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_ack_ignored: InstrValid=%b required 0", InstrValid); end
        @(negedge clk);
        nCompared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            nMismatched++; $display("[TB] FAIL fetch_hold: req=%b addr=%h required 1/00003000", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h2108_0001;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        nCompared++;
        if (InstrValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL issue_valid: got %b required 1", InstrValid); end
        nCompared++;
        if (Instr !== 32'h2108_0001) begin nMismatched++; $display("[TB] FAIL issue_instr: got %h required 21080001", Instr); end
        nCompared++;
        if (RetireCnt !== 32'h0) begin nMismatched++; $display("[TB] FAIL issue_retire0: got %h required 0", RetireCnt); end
        nCompared++;
        if (imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL issue_req_low: got %b required 0", imem_req); end
    endtask

    task automatic test_jump;
        logic [31:0] expLink;
`ifdef PC_FETCH_DELAY_SLOT_EN
        expLink = 32'h0000_3008;
`else
        expLink = 32'h0000_3004;
`endif
        nCompared++;
        if (LinkAddr !== expLink) begin nMismatched++; $display("[TB] FAIL jump_link: got %h required %h", LinkAddr, expLink); end
        issueInstr(1'b1, 1'b0, 1'b1, 16'h0000, 26'h0000C40);
`ifdef PC_FETCH_DELAY_SLOT_EN
        nCompared++;
        if (imem_addr !== 32'h0000_3004) begin nMismatched++; $display("[TB] FAIL delay_slot_addr: got %h required 00003004", imem_addr); end
        fetchInstr(32'h0000_0000);
        issueInstr(1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000040);
`endif
        nCompared++;
        if (imem_addr !== 32'h0000_3100) begin nMismatched++; $display("[TB] FAIL jump_target: got %h required 00003100", imem_addr); end
        nCompared++;
        if (RetireCnt !== expRetire) begin nMismatched++; $display("[TB] FAIL jump_retire: got %h required %h", RetireCnt, expRetire); end
        fetchInstr(32'h1111_1111);
        nCompared++;
        if (PC !== 32'h0000_3100) begin nMismatched++; $display("[TB] FAIL jump_pc: got %h required 00003100", PC); end
    endtask

    task automatic test_stall;
        Stall = 1'b1; Branch = 1'b1; Zero = 1'b1; Jump = 1'b0; Target26 = 26'h3FF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nCompared++;
            if (Instr !== 32'h1111_1111 || PC !== 32'h0000_3100) begin
                nMismatched++; $display("[TB] FAIL stall_hold[%0d]: instr=%h pc=%h required 11111111/00003100", i, Instr, PC);
            end
            nCompared++;
            if (RetireCnt !== expRetire) begin nMismatched++; $display("[TB] FAIL stall_retire[%0d]: got %h required %h", i, RetireCnt, expRetire); end
            nCompared++;
            if (imem_req !== 1'b0 || InstrValid !== 1'b1) begin
                nMismatched++; $display("[TB] FAIL stall_ctrl[%0d]: req=%b valid=%b required 0/1", i, imem_req, InstrValid);
            end
        end
        issueInstr(1'b0, 1'b1, 1'b0, 16'h0000, 26'h0);
        nCompared++;
        if (imem_addr !== 32'h0000_3104) begin nMismatched++; $display("[TB] FAIL stall_release_addr: got %h required 00003104", imem_addr); end
        nCompared++;
        if (RetireCnt !== expRetire) begin nMismatched++; $display("[TB] FAIL stall_release_retire: got %h required %h", RetireCnt, expRetire); end
    endtask

    task automatic test_branch;
        fetchInstr(32'h2222_2222);
        redirectInstr(1'b1, 1'b1, 1'b1, 16'hFFC2, 26'h0);
        nCompared++;
        if (imem_addr !== 32'h0000_3010) begin nMismatched++; $display("[TB] FAIL branch_back_far: got %h required 00003010", imem_addr); end
        fetchInstr(32'h3333_3333);
        redirectInstr(1'b1, 1'b1, 1'b1, 16'hFFFE, 26'h0);
        nCompared++;
        if (imem_addr !== 32'h0000_300C) begin nMismatched++; $display("[TB] FAIL branch_neg: got %h required 0000300c", imem_addr); end
        fetchInstr(32'h4444_4444);
        issueInstr(1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0);
        nCompared++;
        if (imem_addr !== 32'h0000_3010) begin nMismatched++; $display("[TB] FAIL branch_zero_clear: got %h required 00003010", imem_addr); end
        fetchInstr(32'h5555_5555);
        issueInstr(1'b0, 1'b1, 1'b1, 16'hFFFE, 26'h0);
        nCompared++;
        if (imem_addr !== 32'h0000_3014) begin nMismatched++; $display("[TB] FAIL branch_not_branch: got %h required 00003014", imem_addr); end
        nCompared++;
        if (RetireCnt !== expRetire) begin nMismatched++; $display("[TB] FAIL branch_retire: got %h required %h", RetireCnt, expRetire); end
    endtask

    task automatic test_wrap;
        logic [31:0] expLink;
`ifdef PC_FETCH_DELAY_SLOT_EN
        expLink = 32'h0000_0004;
`else
        expLink = 32'h0000_0000;
`endif
        fetchInstr(32'h6666_6666);
        redirectInstr(1'b1, 1'b1, 1'b1, 16'hF3F9, 26'h0);
        nCompared++;
        if (imem_addr !== 32'hFFFF_FFFC) begin nMismatched++; $display("[TB] FAIL wrap_setup: got %h required fffffffc", imem_addr); end
        fetchInstr(32'h7777_7777);
        nCompared++;
        if (LinkAddr !== expLink) begin nMismatched++; $display("[TB] FAIL wrap_link: got %h required %h", LinkAddr, expLink); end
        issueInstr(1'b0, 1'b1, 1'b0, 16'h0000, 26'h0);
        nCompared++;
        if (imem_addr !== 32'h0000_0000) begin nMismatched++; $display("[TB] FAIL wrap_pc: got %h required 00000000", imem_addr); end
    endtask

    task automatic test_reset_mid_fetch;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        nCompared++;
        if (imem_req !== 1'b0 || PC !== 32'h0000_3000 || RetireCnt !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL midreset_state: req=%b pc=%h retire=%h required 0/00003000/0", imem_req, PC, RetireCnt);
        end
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        nCompared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            nMismatched++; $display("[TB] FAIL midreset_refetch: req=%b addr=%h required 1/00003000", imem_req, imem_addr);
        end
        nCompared++;
        if (InstrValid !== 1'b0 || Instr !== 32'h0) begin
            nMismatched++; $display("[TB] FAIL midreset_ack_ignored: valid=%b instr=%h required 0/00000000", InstrValid, Instr);
        end
        @(negedge clk);
        nCompared++;
        if (imem_req !== 1'b1 || InstrValid !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL midreset_still_fetch: req=%b valid=%b required 1/0", imem_req, InstrValid);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
